// File: rtl/mdu_seq.sv
// Sequential multiply/divide unit with architectural HI/LO and fixed-latency busy window.
// Define MDU_MADD_EN to enable the MADD/MADDU/MSUB/MSUBU accumulate ops (7-10).
module mdu_seq #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  op,
   input  logic        cancel,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [63:0] pend_q, pend_d;
   logic        wr_q, wr_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;

   logic op_mul, op_mulu, op_div, op_divu, op_mthi, op_mtlo, op_mac, op_sub, op_valid;
   logic launch, run_op;

   always_comb begin
      op_mul  = 1'b0;
      op_mulu = 1'b0;
      op_div  = 1'b0;
      op_divu = 1'b0;
      op_mthi = 1'b0;
      op_mtlo = 1'b0;
      op_mac  = 1'b0;
      op_sub  = 1'b0;
      case (op)
         4'd1:    op_mul  = 1'b1;
         4'd2:    op_mulu = 1'b1;
         4'd3:    op_div  = 1'b1;
         4'd4:    op_divu = 1'b1;
         4'd5:    op_mthi = 1'b1;
         4'd6:    op_mtlo = 1'b1;
`ifdef MDU_MADD_EN
         4'd7:    begin op_mac = 1'b1; op_mul  = 1'b1; end
         4'd8:    begin op_mac = 1'b1; op_mulu = 1'b1; end
         4'd9:    begin op_mac = 1'b1; op_mul  = 1'b1; op_sub = 1'b1; end
         4'd10:   begin op_mac = 1'b1; op_mulu = 1'b1; op_sub = 1'b1; end
`endif
         default: ;
      endcase
      op_valid = op_mul | op_mulu | op_div | op_divu | op_mthi | op_mtlo;
   end

   assign run_op = op_mul | op_mulu | op_div | op_divu;
   assign launch = start & ~cancel & ~busy & op_valid;

   // Sign-extending per op lets one unsigned 64x64 multiplier serve both signednesses.
   logic [63:0] mul_a, mul_b, prod;
   assign mul_a = {{32{op_mul & A[31]}}, A};
   assign mul_b = {{32{op_mul & B[31]}}, B};
   assign prod  = mul_a * mul_b;

   logic [63:0] mul_res;
`ifdef MDU_MADD_EN
   always_comb begin
      mul_res = prod;
      if (op_mac) mul_res = op_sub ? ({hi_q, lo_q} - prod) : ({hi_q, lo_q} + prod);
   end
`else
   assign mul_res = prod;
`endif

   // Magnitude division; quotient sign from operand XOR, remainder takes dividend sign.
   logic        a_neg, b_neg;
   logic [31:0] a_mag, b_mag, divisor, q_mag, r_mag, quo, rem;
   assign a_neg   = op_div & A[31];
   assign b_neg   = op_div & B[31];
   assign a_mag   = a_neg ? (32'd0 - A) : A;
   assign b_mag   = b_neg ? (32'd0 - B) : B;
   assign divisor = (B == 32'd0) ? 32'd1 : b_mag;
   assign q_mag   = a_mag / divisor;
   assign r_mag   = a_mag % divisor;
   assign quo     = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
   assign rem     = a_neg ? (32'd0 - r_mag) : r_mag;

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (launch && run_op) state_d = RUN;
         RUN:     if (cnt_q == 4'd1)    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q == RUN);
   end

   always_comb begin
      cnt_d  = cnt_q;
      pend_d = pend_q;
      wr_d   = wr_q;
      hi_d   = hi_q;
      lo_d   = lo_q;
      if (state_q == RUN) begin
         cnt_d = cnt_q - 4'd1;
         if (cnt_q == 4'd1) begin
            cnt_d = 4'd0;
            if (wr_q) {hi_d, lo_d} = pend_q;
         end
      end else if (launch) begin
         if (op_mthi) hi_d = A;
         if (op_mtlo) lo_d = A;
         if (op_mul || op_mulu) begin
            cnt_d  = 4'(MULT_CYCLES);
            pend_d = mul_res;
            wr_d   = 1'b1;
         end
         if (op_div || op_divu) begin
            cnt_d  = 4'(DIV_CYCLES);
            pend_d = {rem, quo};
            wr_d   = (B != 32'd0);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q  <= 4'd0;
         pend_q <= 64'd0;
         wr_q   <= 1'b0;
         hi_q   <= 32'd0;
         lo_q   <= 32'd0;
      end else begin
         cnt_q  <= cnt_d;
         pend_q <= pend_d;
         wr_q   <= wr_d;
         hi_q   <= hi_d;
         lo_q   <= lo_d;
      end
   end

   assign hi = hi_q;
   assign lo = lo_q;

endmodule
